// File: rtl/ifid_fetch.sv
// Fetch stage and IF/ID pipeline register: owns the PC, issues icache reads,
// and parks an instruction that hits during a stall in a one-entry hold buffer.
module ifid_fetch #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [31:0] PC_INC  = 32'd4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr,
  output logic [31:0] npc,
  output logic        valid
);

  typedef enum logic [1:0] {RUN, HOLD, HALTED} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] npc_q;
  logic        valid_q;
  logic [31:0] buf_instr_q;
  logic [31:0] buf_npc_q;
  logic [31:0] pc_inc_d;

  // Modulo-2^32 add; the top of the address space wraps to zero.
  assign pc_inc_d = pc_q + PC_INC;

  assign iaddr = pc_q;
  assign iREN  = (state_q == RUN) && !halt;
  assign instr = instr_q;
  assign npc   = npc_q;
  assign valid = valid_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      pc_q        <= PC_INIT;
      instr_q     <= '0;
      npc_q       <= '0;
      valid_q     <= 1'b0;
      buf_instr_q <= '0;
      buf_npc_q   <= '0;
    end else if (halt || state_q == HALTED) begin
      state_q <= HALTED;
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else if (redirect || flush) begin
      // Both squash IF/ID and drop any parked instruction; only redirect moves the PC.
      if (redirect) pc_q <= redirect_pc;
      state_q <= RUN;
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (ihit) begin
            pc_q <= pc_inc_d;
            if (stall) begin
              buf_instr_q <= iload;
              buf_npc_q   <= pc_inc_d;
              state_q     <= HOLD;
            end else begin
              instr_q <= iload;
              npc_q   <= pc_inc_d;
              valid_q <= 1'b1;
            end
          end else if (!stall) begin
            instr_q <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_q <= buf_instr_q;
            npc_q   <= buf_npc_q;
            valid_q <= 1'b1;
            state_q <= RUN;
          end
        end
        default: state_q <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_ifid_fetch.sv
// Directed-vector bench for ifid_fetch with hand-computed expected values.
module tb_ifid_fetch;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] instr;
  logic [31:0] npc;
  logic        valid;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  localparam logic [31:0] IA = 32'h1111_1111;
  localparam logic [31:0] IB = 32'h2222_2222;
  localparam logic [31:0] IC = 32'h3333_3333;
  localparam logic [31:0] IX = 32'hAAAA_0001;
  localparam logic [31:0] IY = 32'hBBBB_0002;
  localparam logic [31:0] IZ = 32'hCCCC_0003;
  localparam logic [31:0] IW = 32'hDDDD_0004;
  localparam logic [31:0] IV = 32'hEEEE_0005;

  ifid_fetch #(.PC_INIT(32'h0000_0000), .PC_INC(32'd4)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .iREN(iREN), .iaddr(iaddr),
    .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .instr(instr), .npc(npc), .valid(valid)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] ei, input logic [31:0] en,
                            input logic ev);
    check({tag, ".instr"}, instr, ei);
    check({tag, ".npc"}, npc, en);
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, ev});
  endtask

  task automatic step(input logic h, input logic [31:0] ld, input logic st, input logic fl,
                      input logic rd, input logic [31:0] rpc, input logic hl);
    ihit = h; iload = ld; stall = st; flush = fl; redirect = rd; redirect_pc = rpc; halt = hl;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    ihit = 0; iload = '0; stall = 0; flush = 0; redirect = 0; redirect_pc = '0; halt = 0;
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    ihit = 0; iload = '0; stall = 0; flush = 0; redirect = 0; redirect_pc = '0; halt = 0;
    #3;
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check("rst.iaddr", iaddr, 32'h0);
    check("rst.iREN", {31'd0, iREN}, 32'd1);
    @(negedge CLK);
    nRST = 1'b1;

    // T1: back-to-back hits
    step(1, IA, 0, 0, 0, '0, 0); check_ifid("t1a", IA, 32'd4, 1'b1);
    step(1, IB, 0, 0, 0, '0, 0); check_ifid("t1b", IB, 32'd8, 1'b1);
    step(1, IC, 0, 0, 0, '0, 0); check_ifid("t1c", IC, 32'd12, 1'b1);
    check("t1.iaddr", iaddr, 32'd12);

    // T2: misses produce bubbles and freeze the PC
    pulse_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      step(0, IB, 0, 0, 0, '0, 0);
      check_ifid("t2miss", 32'h0, 32'h0, 1'b0);
      check("t2.iaddr", iaddr, 32'h0);
    end
    step(1, IA, 0, 0, 0, '0, 0); check_ifid("t2hit", IA, 32'd4, 1'b1);

    // T3: hit under stall parks in the hold buffer
    step(1, IB, 0, 0, 0, '0, 0); check_ifid("t3pre", IB, 32'd8, 1'b1);
    step(1, IX, 1, 0, 0, '0, 0); check_ifid("t3hold", IB, 32'd8, 1'b1);
    check("t3.iREN", {31'd0, iREN}, 32'd0);
    check("t3.iaddr", iaddr, 32'd12);
    step(1, IC, 1, 0, 0, '0, 0); check_ifid("t3hold2", IB, 32'd8, 1'b1);
    check("t3.iaddr2", iaddr, 32'd12);
    step(0, IC, 0, 0, 0, '0, 0); check_ifid("t3rel", IX, 32'd12, 1'b1);
    check("t3.iREN2", {31'd0, iREN}, 32'd1);
    check("t3.iaddr3", iaddr, 32'd12);

    // T4: redirect during HOLD drops the buffer
    step(1, IY, 1, 0, 0, '0, 0); check_ifid("t4hold", IX, 32'd12, 1'b1);
    step(0, IC, 1, 0, 1, 32'h40, 0); check_ifid("t4redir", 32'h0, 32'h0, 1'b0);
    check("t4.iaddr", iaddr, 32'h40);
    check("t4.iREN", {31'd0, iREN}, 32'd1);
    step(0, IC, 0, 0, 0, '0, 0); check_ifid("t4after", 32'h0, 32'h0, 1'b0);
    check("t4.iaddr2", iaddr, 32'h40);

    // T5: flush discards a same-cycle hit without advancing the PC
    step(0, IC, 0, 0, 1, 32'h10, 0); check("t5.iaddr0", iaddr, 32'h10);
    step(1, IZ, 0, 1, 0, '0, 0); check_ifid("t5flush", 32'h0, 32'h0, 1'b0);
    check("t5.iaddr", iaddr, 32'h10);
    step(1, IZ, 0, 0, 0, '0, 0); check_ifid("t5refetch", IZ, 32'h14, 1'b1);

    // PC wrap and stall-on-miss holding IF/ID
    step(0, IC, 0, 0, 1, 32'hFFFF_FFFC, 0);
    step(1, IW, 0, 0, 0, '0, 0); check_ifid("wrap", IW, 32'h0, 1'b1);
    check("wrap.iaddr", iaddr, 32'h0);
    step(0, IC, 1, 0, 0, '0, 0); check_ifid("stallmiss", IW, 32'h0, 1'b1);
    check("stallmiss.iaddr", iaddr, 32'h0);
    step(1, IV, 0, 0, 0, '0, 0); check_ifid("prehalt", IV, 32'd4, 1'b1);

    // T6: halt is sticky until reset
    step(1, IA, 0, 0, 0, '0, 1); check_ifid("t6halt", 32'h0, 32'h0, 1'b0);
    check("t6.iREN", {31'd0, iREN}, 32'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      step(1, IB, i[0], 0, i[1], 32'h80, 0);
      check_ifid("t6sticky", 32'h0, 32'h0, 1'b0);
      check("t6.iREN2", {31'd0, iREN}, 32'd0);
      check("t6.iaddr", iaddr, 32'd4);
    end
    pulse_reset();
    check("t6.rst.iaddr", iaddr, 32'h0);
    check("t6.rst.iREN", {31'd0, iREN}, 32'd1);
    step(1, IA, 0, 0, 0, '0, 0); check_ifid("t6run", IA, 32'd4, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
